// File: rtl/seq_mem_pkg.sv
// Shared types, limits and the byte-lane merge helper used by the 1R1W sequential memory.
package seq_mem_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  localparam int MAX_READ_LAT = 4;
  localparam int MAX_WIDTH    = 512;
  localparam int MAX_BYTES    = MAX_WIDTH / 8;

  // Callers zero-extend narrower words; bytes with a set mask bit come from newWord.
  function automatic logic [MAX_WIDTH-1:0] byte_merge(
    input logic [MAX_WIDTH-1:0] oldWord,
    input logic [MAX_WIDTH-1:0] newWord,
    input logic [MAX_BYTES-1:0] mask
  );
    logic [MAX_WIDTH-1:0] merged;
    merged = oldWord;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (mask[b]) merged[8*b +: 8] = newWord[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/seq_mem_rd_pipe.sv
// Read-data delay line of DEPTH valid+data stages; data advances only with valid, so the
// last stage keeps the most recently completed read. DEPTH=0 passes the input straight through.
module seq_mem_rd_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : gPass
    logic unusedClkRst;
    assign unusedClkRst = clk ^ reset;
    assign valid_o      = valid_i;
    assign data_o       = data_i;
  end else begin : gStages
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= valid_i;
        if (valid_i) data_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/seq_mem_d1_1r1w_pipe.sv
// One-read/one-write sequential memory: byte-masked writes, READ_LAT-cycle pipelined reads,
// selectable read-during-write result and a sticky out-of-bounds error flag.
module seq_mem_d1_1r1w_pipe
  import seq_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4,
  parameter int READ_LAT = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_SIZE-1:0] raddr_i,
  input  logic                read_en_i,
  output logic [WIDTH-1:0]    out_o,
  output logic                read_done_o,
  input  logic [IDX_SIZE-1:0] waddr_i,
  input  logic [WIDTH-1:0]    in_i,
  input  logic [WIDTH/8-1:0]  wmask_i,
  input  logic                write_en_i,
  output logic                write_done_o,
  output logic                err_oob_o
);

  localparam rdw_mode_e         RdwMode   = (RDW_MODE == 1) ? RDW_NEW : RDW_OLD;
  localparam logic [IDX_SIZE:0] SizeLimit = (IDX_SIZE+1)'(SIZE);

  if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : gBadLat
    $fatal(1, "seq_mem_d1_1r1w_pipe: READ_LAT=%0d outside 1..%0d", READ_LAT, MAX_READ_LAT);
  end
  if ((WIDTH % 8) != 0 || WIDTH > MAX_WIDTH) begin : gBadWidth
    $fatal(1, "seq_mem_d1_1r1w_pipe: WIDTH=%0d must be a multiple of 8 up to %0d", WIDTH, MAX_WIDTH);
  end
  if ((1 << IDX_SIZE) < SIZE) begin : gBadIdx
    $fatal(1, "seq_mem_d1_1r1w_pipe: IDX_SIZE=%0d too small for SIZE=%0d", IDX_SIZE, SIZE);
  end

  logic [WIDTH-1:0]     mem_q [SIZE];
  logic                 rdInBounds, wrInBounds, sameAddr;
  logic [WIDTH-1:0]     readOld, writeOld, writeMerged, readWord;
  logic [MAX_WIDTH-1:0] oldExt, newExt, mergedExt;
  logic [MAX_BYTES-1:0] maskExt;
  logic                 unusedMergeHi;

  logic             rdValid_q, rdValid_d;
  logic [WIDTH-1:0] rdData_q, rdData_d;
  logic             writeDone_q, writeDone_d;
  logic             errOob_q, errOob_d;

  // Compare at IDX_SIZE+1 bits so SIZE == 2**IDX_SIZE never wraps to zero.
  assign rdInBounds = {1'b0, raddr_i} < SizeLimit;
  assign wrInBounds = {1'b0, waddr_i} < SizeLimit;
  assign sameAddr   = raddr_i == waddr_i;

  always_comb begin
    readOld  = rdInBounds ? mem_q[raddr_i] : '0;
    writeOld = wrInBounds ? mem_q[waddr_i] : '0;
    oldExt   = '0;
    newExt   = '0;
    maskExt  = '0;
    oldExt[WIDTH-1:0]    = writeOld;
    newExt[WIDTH-1:0]    = in_i;
    maskExt[WIDTH/8-1:0] = wmask_i;
    mergedExt   = byte_merge(oldExt, newExt, maskExt);
    writeMerged = mergedExt[WIDTH-1:0];
    readWord    = readOld;
    if (RdwMode == RDW_NEW && write_en_i && wrInBounds && sameAddr) readWord = writeMerged;
  end

  assign unusedMergeHi = ^mergedExt;

  // Memory contents survive reset, so a write coincident with reset still lands.
  always_ff @(posedge clk) begin
    if (write_en_i && wrInBounds) mem_q[waddr_i] <= writeMerged;
  end

  always_comb begin
    rdValid_d   = read_en_i;
    rdData_d    = read_en_i ? readWord : rdData_q;
    writeDone_d = write_en_i;
    errOob_d    = errOob_q | (read_en_i & ~rdInBounds) | (write_en_i & ~wrInBounds);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
      writeDone_q <= 1'b0;
      errOob_q    <= 1'b0;
    end else begin
      rdValid_q   <= rdValid_d;
      rdData_q    <= rdData_d;
      writeDone_q <= writeDone_d;
      errOob_q    <= errOob_d;
    end
  end

  seq_mem_rd_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(READ_LAT - 1)
  ) rdPipe (
    .clk    (clk),
    .reset  (reset),
    .valid_i(rdValid_q),
    .data_i (rdData_q),
    .valid_o(read_done_o),
    .data_o (out_o)
  );

  assign write_done_o = writeDone_q;
  assign err_oob_o    = errOob_q;

endmodule

// File: doc/seq_mem_d1_1r1w_pipe.md
Name: seq_mem_d1_1r1w_pipe

Overview:
Parametrised successor to the single-port sequential memory. It provides one read port and one independent write port, with byte-masked writes and a configurable read-pipeline latency. It has a defined read-during-write policy and a sticky out-of-bounds error flag. It is used as the backing store for Calyx-generated designs that need concurrent read/write and deeper, timing-friendly read paths.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8
SIZE, 16, number of words
IDX_SIZE, 4, address width; must satisfy 2**IDX_SIZE >= SIZE
READ_LAT, 1, cycles from read_en to out/read_done; legal range 1..4
RDW_MODE, 0, same-address read/write in one cycle: 0 = old data, 1 = new (merged) data

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
raddr  in  IDX_SIZE  read address
read_en  in  1  read request, one word per cycle
out  out  WIDTH  registered read data
read_done  out  1  one-cycle pulse, aligned with out update
waddr  in  IDX_SIZE  write address
in  in  WIDTH  write data
wmask  in  WIDTH/8  byte enables; bit i covers in[8i+7:8i]
write_en  in  1  write request
write_done  out  1  one-cycle pulse, one cycle after write_en
err_oob  out  1  sticky flag: an out-of-bounds access occurred

Behaviour:
- Reset (synchronous, active-high; clock clk): out=0, read_done=0, write_done=0, err_oob=0, all pipeline valid bits cleared. Memory contents are not reset.
- Read:
  - read_en sampled at edge T captures mem[raddr] (subject to the RDW rule).
  - Data passes through READ_LAT-1 further register stages.
  - out updates and read_done=1 at edge T+READ_LAT-1, i.e. visible during cycle T+READ_LAT relative to the request.
  - Fully pipelined: back-to-back read_en yields back-to-back read_done.
- out holding: out holds its last value whenever no read completes. There is no clobbering on write; this differs from the single-port block.
- Write:
  - write_en at edge T updates bytes of mem[waddr] whose wmask bit is 1; other bytes are unchanged.
  - write_done=1 in the following cycle.
  - wmask=0 still pulses write_done and leaves memory unchanged.
- Simultaneous read and write:
  - Legal.
  - Different addresses: independent.
  - Same address, RDW_MODE=0: the read returns the pre-write word.
  - Same address, RDW_MODE=1: the read returns the merged word (masked bytes from in, remaining bytes old).
- Out of bounds (address >= SIZE):
  - Read returns 0 with a normal read_done.
  - Write is dropped; write_done still pulses.
  - Either case sets err_oob at the next edge; it stays set until reset.
- Reset mid-operation: in-flight reads are discarded. No read_done is produced for any request sampled before or during the reset cycle. A write coincident with reset is still performed, because memory is not reset; write_done stays 0.
- Requests during reset are otherwise ignored for done and err signalling.
- Width rules: the address compares against SIZE at IDX_SIZE+1 bits; there is no wrap-around.
- Elaboration: READ_LAT outside 1..4, or WIDTH%8 != 0, is an error ($fatal).

Decomposition:
- Package seq_mem_pkg:
  - rdw_mode_e enum (RDW_OLD=0, RDW_NEW=1)
  - MAX_READ_LAT=4
  - function byte_merge(old, new, mask) returning the merged word
- Sub-module seq_mem_rd_pipe:
  - parameters WIDTH and DEPTH=READ_LAT-1, a valid+data shift register with synchronous clear
  - DEPTH=0 is a passthrough of the first-stage register
- Top level holds the memory array, the RDW/merge logic, the first read register, the done flags and err_oob.

Test Plan:
- Write and read back: READ_LAT=1, write 0xDEADBEEF @3 with wmask=4'hF, then read @3 -> write_done pulses 1 cycle later; read_done and out=0xDEADBEEF 1 cycle after read_en.
- Byte mask: mem[5]=0x11223344, then write 0xAABBCCDD with wmask=4'b0101, then read @5 -> out=0x11BB33DD.
- Same-address RDW: mem[2]=0x0, same-cycle write 0xFFFFFFFF @2 and read @2 -> RDW_MODE=0 gives out=0x00000000; RDW_MODE=1 gives 0xFFFFFFFF.
- Pipelined latency: READ_LAT=3, read_en held 4 cycles on addresses 0..3 holding 10..13 -> read_done high for 4 consecutive cycles starting 3 cycles after the first request; out=10,11,12,13; out holds 13 afterwards.
- Out of bounds: SIZE=12, read @14 -> out=0, read_done=1, err_oob=1 and stays set. Then write @13 -> memory unchanged (verify by reading all 12 words).
- Reset mid-read: READ_LAT=4, issue 2 reads, assert reset for 1 cycle 2 cycles later -> no read_done, out=0, err_oob=0 after reset. A subsequent read returns the correct data.
